// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline control logic.
// Holds the hazard FSM state encoding, the hard-wired zero register index and the NOP word.
package pipeline_pkg;

    typedef enum logic {
        StRun,
        StMemWait
    } hazard_state_e;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    // sll $0, $0, 0 -- what IF/ID holds after a flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_perf_counter.sv
// Free-running wrap-around event counter with increment enable.
module hazard_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Load-use / memory-wait / branch-flush hazard controller for the 5-stage pipeline.
// Control outputs are combinational from state and inputs; counters and the timeout flag are registered.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 1023,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead_EX,
    input  logic [4:0]       Rt_EX,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             usesRt_ID,
    input  logic             branchTaken_ID,
    input  logic             memReq_MEM,
    input  logic             memReady_MEM,
    output logic             Hazard,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             PipeHold,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] bubbleCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    hazard_state_e state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic mem_timeout_q, mem_timeout_d;
    logic load_use, mem_busy;

    assign load_use = MemRead_EX && (Rt_EX != REG_ZERO) &&
                      ((Rt_EX == Rs_ID) || (usesRt_ID && (Rt_EX == Rt_ID)));
    assign mem_busy = memReq_MEM && !memReady_MEM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:     if (mem_busy) state_d = StMemWait;
            StMemWait: if (memReady_MEM) state_d = StRun;
            default:   state_d = StRun;
        endcase
    end

    // Priority: reset > memory wait > load-use bubble > branch flush
    always_comb begin
        Hazard      = 1'b0;
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        PipeHold    = 1'b0;
        if (!rst_n) begin
            Hazard      = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
        end else if ((state_q == StMemWait) || mem_busy) begin
            PipeHold    = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
        end else if (load_use) begin
            Hazard      = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
        end else if (branchTaken_ID) begin
            IF_ID_Flush = 1'b1;
        end
    end

    // Consecutive MEM_WAIT cycles, saturating; the flag is sticky until reset
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == StMemWait) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        mem_timeout_d = mem_timeout_q || (wait_cnt_d == WAIT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign memTimeout = mem_timeout_q;

    hazard_perf_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (!PCWrite),
        .count  (stallCycles)
    );

    hazard_perf_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (Hazard),
        .count  (bubbleCount)
    );

    hazard_perf_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (IF_ID_Flush),
        .count  (flushCount)
    );

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core. It detects load-use hazards between ID and EX and drives the `Hazard` bubble input of the ID/EX register. It also freezes the whole pipeline while data memory is not ready, flushes IF/ID on taken branches, and keeps stall/bubble/flush performance counters plus a sticky memory-timeout flag. It sits beside the ID stage and fans out to PC, IF/ID, ID/EX and the EX/MEM and MEM/WB hold inputs.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 1023: number of consecutive not-ready cycles after which `memTimeout` sets. Minimum 1.
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clk`, input, 1: single clock, all state on rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `MemRead_EX`, input, 1: instruction in EX is a load.
- `Rt_EX`, input, 5: destination register of the EX-stage load.
- `Rs_ID`, input, 5: source register of the ID-stage instruction.
- `Rt_ID`, input, 5: second source register of the ID-stage instruction.
- `usesRt_ID`, input, 1: the ID-stage instruction reads Rt (R-type, store, branch).
- `branchTaken_ID`, input, 1: branch in ID resolved as taken.
- `memReq_MEM`, input, 1: load or store in MEM.
- `memReady_MEM`, input, 1: data memory completes this cycle.
- `Hazard`, output, 1: to ID/EX; 1 inserts a bubble (control bits zeroed).
- `PCWrite`, output, 1: PC update enable.
- `IF_ID_Write`, output, 1: IF/ID load enable.
- `IF_ID_Flush`, output, 1: IF/ID clears to NOP.
- `PipeHold`, output, 1: ID/EX, EX/MEM and MEM/WB hold their contents.
- `memTimeout`, output, 1: sticky error flag.
- `stallCycles`, `bubbleCount`, `flushCount`, output, CNT_W each: performance counters.

## Operation
- loadUse = MemRead_EX && Rt_EX != 0 && (Rt_EX == Rs_ID || (usesRt_ID && Rt_EX == Rt_ID)).
- memBusy = memReq_MEM && !memReady_MEM.
- The FSM has two states, RUN and MEM_WAIT.
- RUN, priority is memBusy > loadUse > branchTaken_ID:
  - memBusy: go to MEM_WAIT. Outputs this cycle: PipeHold=1, PCWrite=0, IF_ID_Write=0, Hazard=0, IF_ID_Flush=0.
  - loadUse: stay in RUN. Outputs: Hazard=1, PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, PipeHold=0.
  - branchTaken_ID: stay in RUN. Outputs: IF_ID_Flush=1, PCWrite=1, IF_ID_Write=1, Hazard=0.
  - None of the above: PCWrite=1, IF_ID_Write=1, all other control outputs 0.
- MEM_WAIT: outputs are the same as the memBusy case. Leave for RUN on the first cycle memReady_MEM=1. That cycle still holds: PipeHold=1, and loadUse and branch are ignored. The pipeline advances on the next edge.
- A load-use stall produces exactly one bubble. The following cycle MemRead_EX is 0 because of the bubble, so the hazard is not re-detected.
- A taken branch during a load-use stall is suppressed and is re-evaluated once the stall clears.
- Counters:
  - stallCycles counts cycles with PCWrite=0.
  - bubbleCount counts cycles with Hazard=1.
  - flushCount counts cycles with IF_ID_Flush=1.
  - All counters wrap modulo 2^CNT_W.
- Timeout: a wait counter counts consecutive cycles spent in MEM_WAIT and clears in RUN.
  - memTimeout sets when the counter reaches MEM_TIMEOUT and is cleared only by reset.
  - The counter saturates at MEM_TIMEOUT.
  - Setting memTimeout does not release the stall.

## Timing
- Reset (rst_n=0, asynchronous):
  - State goes to RUN; counters, wait counter and memTimeout go to 0.
  - While rst_n=0, outputs are forced: Hazard=1, PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, PipeHold=0.
- Reset asserted mid-stall aborts MEM_WAIT immediately.
- After rst_n rises, the first edge behaves as RUN.
- All control outputs are combinational from the state and the current inputs, with zero latency.
- Counters and memTimeout are registered and update on the edge following the qualifying cycle.

## Structure
- `pipeline_pkg` holds:
  - the state enum (RUN, MEM_WAIT);
  - the `REG_ZERO` constant (5'd0);
  - the NOP encoding used by IF/ID flush.
- One sub-module, `hazard_perf_counter`: a CNT_W-bit wrap counter with an increment enable and async active-low reset, instantiated three times.
- Detection logic and the FSM stay in `hazard_unit`.

## Test plan
- Load-use on Rs: MemRead_EX=1, Rt_EX=5, Rs_ID=5 for one cycle -> Hazard=1, PCWrite=0, IF_ID_Write=0 that cycle; bubbleCount=1 and stallCycles=1 after the edge.
- Register $0 and the usesRt gate:
  - Rt_EX=0=Rs_ID -> Hazard=0.
  - Rt_EX=7=Rt_ID with usesRt_ID=0 -> Hazard=0.
  - Same case with usesRt_ID=1 -> Hazard=1.
- Memory wait: memReq_MEM=1 with memReady_MEM=0 for 3 cycles, then 1 -> PipeHold=1 for 4 cycles and then 0; stallCycles=4.
- Priority: loadUse and branchTaken_ID together -> Hazard=1, IF_ID_Flush=0. Adding memBusy on top -> PipeHold=1, Hazard=0.
- Timeout: MEM_TIMEOUT=4 with memReady_MEM held at 0 -> memTimeout rises after 4 MEM_WAIT cycles and stays 1 after ready returns, until rst_n=0.
- Reset mid-wait and counter wrap:
  - Drop rst_n during MEM_WAIT -> outputs take their reset values immediately and all counters read 0.
  - With CNT_W=4, 17 flushes -> flushCount=1.
